// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: next-PC operation encodings shared by the decoder and the fetch sequencer
package pc_sequencer_pkg;
    localparam logic [2:0] PC_INC    = 3'b000;
    localparam logic [2:0] PC_BRANCH = 3'b001;
    localparam logic [2:0] PC_JUMP   = 3'b010;
    localparam logic [2:0] PC_CALL   = 3'b011;
    localparam logic [2:0] PC_RET    = 3'b100;
endpackage

// File: rtl/pc_sequencer_return_stack.sv
// return_stack: register-array LIFO of return addresses; pushes when full and pops when empty are dropped
module return_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top_data,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       empty,
    output logic                       full
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      cnt;
    logic [PW-1:0]    top_idx;
    logic             do_push, do_pop;
    assign empty    = cnt == '0;
    assign full     = cnt == (PW+1)'(DEPTH);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // the low pointer bits wrap to DEPTH-1 when the stack is full, which is exactly the top slot
    assign top_idx  = cnt[PW-1:0] - 1'b1;
    assign top_data = mem[top_idx];
    assign depth    = cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= do_push ? cnt + 1'b1 : do_pop ? cnt - 1'b1 : cnt;
    end
    always_ff @(posedge clk) begin
        if (do_push)
            mem[cnt[PW-1:0]] <= push_data;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC register with next-PC selection and an internal return-address stack
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                     PC_WIDTH    = 16,
    parameter int                     ADDR_WIDTH  = 10,
    parameter int                     STACK_DEPTH = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic [2:0]                    pc_op,
    input  logic                          branch_taken,
    input  logic [ADDR_WIDTH-1:0]         target_addr,
    input  logic                          clear_err,
    output logic [PC_WIDTH-1:0]           pc,
    output logic [$clog2(STACK_DEPTH):0]  stack_depth,
    output logic                          stack_empty,
    output logic                          stack_full,
    output logic                          stack_overflow,
    output logic                          stack_underflow
);
    logic [PC_WIDTH-1:0] pc_inc, target, top_data, next_pc;
    logic                is_call, is_ret;
    assign pc_inc  = pc + 1'b1;
    assign target  = PC_WIDTH'(target_addr);
    assign is_call = !stall && pc_op == PC_CALL;
    assign is_ret  = !stall && pc_op == PC_RET;
    always_comb begin
        next_pc = (pc_op == PC_JUMP || pc_op == PC_CALL || (pc_op == PC_BRANCH && branch_taken)) ? target :
                  (pc_op == PC_RET && !stack_empty) ? top_data : pc_inc;
    end
    return_stack #(.WIDTH(PC_WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (is_call),
        .pop       (is_ret),
        .push_data (pc_inc),
        .top_data  (top_data),
        .depth     (stack_depth),
        .empty     (stack_empty),
        .full      (stack_full)
    );
    // a new error in the same cycle as clear_err leaves the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc              <= RESET_PC;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            pc              <= stall ? pc : next_pc;
            stack_overflow  <= (is_call && stack_full) || (stack_overflow && !clear_err);
            stack_underflow <= (is_ret && stack_empty) || (stack_underflow && !clear_err);
        end
    end
endmodule
